cpu_run_ctrl: RTL

- Run/step/halt controller for the single-cycle CPU on the FPGA board.
- Generates a one-`clk`-wide clock-enable pulse `cpu_ce` that advances the CPU by exactly one instruction. Pulses come either at a divided free-run rate or one per debounced step-button press.
- Sits between the board buttons and the CPU's state-update enable; also provides a PC breakpoint and an executed-instruction counter for the display.

---
 rtl/cpu_run_ctrl_if.sv | 11 +
 rtl/cpu_run_ctrl.sv | 85 ++++++++
 2 files changed

// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: board buttons, debug controls and CPU-side status of cpu_run_ctrl
interface cpu_run_ctrl_if #(parameter int CNT_W = 32);
  logic btn_run, btn_step, halt_req, bp_arm;
  logic [31:0] pc_in, bp_addr;
  logic cpu_ce, running, bp_hit;
  logic [CNT_W-1:0] instr_cnt;
  modport master (output btn_run, btn_step, halt_req, pc_in, bp_addr, bp_arm,
                  input cpu_ce, running, bp_hit, instr_cnt);
  modport slave (input btn_run, btn_step, halt_req, pc_in, bp_addr, bp_arm,
                 output cpu_ce, running, bp_hit, instr_cnt);
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/halt controller emitting one-clk cpu_ce pulses
// PC breakpoint with skip-past-on-resume is built only when CPU_BREAKPOINT_EN is defined
module cpu_run_ctrl #(
  parameter int DIV = 100000,
  parameter int DB_CYCLES = 20000,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  cpu_run_ctrl_if.slave bus
);
  localparam int PW = $clog2(DIV);
  localparam int DW = $clog2(DB_CYCLES) + 1;
  typedef enum logic [1:0] {HALT, RUN, STEP} state_t;
  state_t state_q;
  logic [PW-1:0] presc_q;
  logic [CNT_W-1:0] cnt_q;
  logic ce_q, running_q;
  logic [1:0] raw, press;
  logic tick, bp_take, ce_d;
  assign raw = {bus.btn_step, bus.btn_run};
  // bit 0 is the run button, bit 1 the step button
  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic s1_q, s2_q, lvl_q, prs_q, flip;
    logic [DW-1:0] dbc_q;
    assign flip = s2_q != lvl_q && dbc_q == DW'(DB_CYCLES - 1);
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        s1_q <= 1'b0;
        s2_q <= 1'b0;
        lvl_q <= 1'b0;
        prs_q <= 1'b0;
        dbc_q <= '0;
      end else begin
        s1_q <= raw[i];
        s2_q <= s1_q;
        dbc_q <= (s2_q != lvl_q && !flip) ? dbc_q + 1'b1 : '0;
        lvl_q <= flip ? s2_q : lvl_q;
        prs_q <= flip && s2_q;
      end
    assign press[i] = prs_q;
  end
  assign tick = state_q == RUN && presc_q == PW'(DIV - 1);
  assign ce_d = !bus.halt_req && (state_q == STEP || (tick && !bp_take && !press[0]));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= HALT;
      running_q <= 1'b0;
      ce_q <= 1'b0;
      cnt_q <= '0;
      presc_q <= '0;
    end else begin
      state_q <= bus.halt_req ? HALT :
                 state_q == HALT ? (press[0] ? RUN : press[1] ? STEP : HALT) :
                 (state_q == STEP || bp_take || press[0]) ? HALT : RUN;
      running_q <= !bus.halt_req &&
                   (state_q == HALT ? press[0] : state_q == RUN && !bp_take && !press[0]);
      ce_q <= ce_d;
      cnt_q <= cnt_q + CNT_W'(ce_d);
      presc_q <= (state_q == RUN && !tick) ? presc_q + 1'b1 : '0;
    end
`ifdef CPU_BREAKPOINT_EN
  logic skip_q, hit_q, go;
  assign go = state_q == HALT && !bus.halt_req && |press;
  assign bp_take = !bus.halt_req && tick && bus.bp_arm && bus.pc_in == bus.bp_addr && !skip_q;
  // skip lets the first instruction after a breakpoint halt execute past it
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      skip_q <= 1'b0;
      hit_q <= 1'b0;
    end else begin
      skip_q <= bp_take || (skip_q && !ce_d);
      hit_q <= bp_take || (hit_q && !go);
    end
  assign bus.bp_hit = hit_q;
`else
  logic unused_bp;
  assign unused_bp = ^{bus.pc_in, bus.bp_addr, bus.bp_arm};
  assign bp_take = 1'b0;
  assign bus.bp_hit = 1'b0;
`endif
  assign bus.cpu_ce = ce_q;
  assign bus.running = running_q;
  assign bus.instr_cnt = cnt_q;
endmodule
